// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU opcode constants and sequencer state type
package cpu_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_JMP = 5'b10100;
    localparam logic [OPC_W-1:0] OP_JZ  = 5'b10101;
    localparam logic [OPC_W-1:0] OP_JN  = 5'b10110;
    localparam logic [OPC_W-1:0] OP_HLT = 5'b10111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/flag_reg.sv
// rtl/flag_reg.sv - zero/negative flag register updated on accumulator writes
module flag_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic              zr,
    output logic              ng
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zr <= 1'b0;
            ng <= 1'b0;
        end else if (we) begin
            zr <= (d == '0);
            ng <= d[DATA_W-1];
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/issue sequencer with PC and flags; FETCH_STEP_EN adds single-step gating
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef FETCH_STEP_EN
    input  logic              step,
`endif
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [OPC_W-1:0]  opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              exec_done,
    input  logic              jump_taken,
    input  logic              acc_we,
    input  logic [DATA_W-1:0] acc_d,
    output logic              zr,
    output logic              ng,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    if (ADDR_W != DATA_W - OPC_W) begin : g_width_check
        $error("ADDR_W must equal DATA_W-OPC_W");
    end

    seq_state_t        state, state_nx;
    logic [DATA_W-1:0] ir;
    logic              go;

`ifdef FETCH_STEP_EN
    logic step_pend;

    // A step arriving in the consuming cycle merges into the request being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_pend <= 1'b0;
        end else if (state == ST_FETCH && step_pend) begin
            step_pend <= 1'b0;
        end else if (step) begin
            step_pend <= 1'b1;
        end
    end

    assign go = step_pend;
`else
    assign go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        imem_en     = 1'b0;
        instr_valid = 1'b0;
        case (state)
            ST_FETCH: begin
                // Reset parks us in FETCH; keep the read strobe quiet until reset lifts.
                imem_en = go & rst_n;
                if (go) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) state_nx = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done) state_nx = ST_FETCH;
            end
            ST_HALT: begin
                state_nx = ST_HALT;
            end
            default: begin
                state_nx = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
            pc <= '0;
        end else begin
            if (state == ST_WAIT) ir <= imem_rdata;
            if (state == ST_EXEC && exec_done) pc <= jump_taken ? operand : pc + ADDR_W'(1);
        end
    end

    assign imem_addr = pc;
    assign opcode    = ir[DATA_W-1 -: OPC_W];
    assign operand   = ir[ADDR_W-1:0];
    assign halted    = (state == ST_HALT);

    flag_reg #(.DATA_W(DATA_W)) u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (acc_we),
        .d     (acc_d),
        .zr    (zr),
        .ng    (ng)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer (schedule model, flag table, random programs)
module tb_fetch_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_en;
    logic [10:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [4:0]  opcode;
    logic [10:0] operand;
    logic        instr_valid;
    logic        instr_ready;
    logic        exec_done;
    logic        jump_taken;
    logic        acc_we;
    logic [15:0] acc_d;
    logic        zr;
    logic        ng;
    logic [10:0] pc;
    logic        halted;
`ifdef FETCH_STEP_EN
    logic        step;
    bit          auto_step;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:2047];
    logic [10:0] mpc;
    logic        mzr, mng;
    bit          rand_acc, junk;

    typedef struct {
        logic        we;
        logic [15:0] d;
        logic        zr;
        logic        ng;
    } fvec_t;
    fvec_t ftab [8];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef FETCH_STEP_EN
        .step        (step),
`endif
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .exec_done   (exec_done),
        .jump_taken  (jump_taken),
        .acc_we      (acc_we),
        .acc_d       (acc_d),
        .zr          (zr),
        .ng          (ng),
        .pc          (pc),
        .halted      (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic common();
        check("pc", pc, mpc);
        check("zr", zr, mzr);
        check("ng", ng, mng);
        if (rand_acc) begin
            acc_we = 1'($urandom);
            acc_d  = ($urandom % 4 == 0) ? 16'h0000 : 16'($urandom);
            if (acc_we) begin
                mzr = (acc_d == 16'h0000);
                mng = acc_d[15];
            end
        end else begin
            acc_we = 1'b0;
        end
    endtask

    task automatic check_reset();
        rst_n  = 1'b0;
        acc_we = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_pc", pc, 0);
            check("rst_imem_en", imem_en, 0);
            check("rst_imem_addr", imem_addr, 0);
            check("rst_opcode", opcode, 0);
            check("rst_operand", operand, 0);
            check("rst_instr_valid", instr_valid, 0);
            check("rst_zr", zr, 0);
            check("rst_ng", ng, 0);
            check("rst_halted", halted, 0);
            next();
        end
        mpc = '0;
        mzr = 1'b0;
        mng = 1'b0;
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
`ifdef FETCH_STEP_EN
        step = 1'b1;
        next();
        step = 1'b0;
`endif
        #1;
    endtask

    // mode 0: full instruction, 1: halt opcode, 2: reset asserted in first EXEC cycle
    task automatic run_instr(input int r, input int d, input bit jt, input int mode);
        logic [15:0] w;
        w = mem[mpc];
        common();
        check("fetch_en", imem_en, 1);
        check("fetch_addr", imem_addr, mpc);
        check("fetch_valid", instr_valid, 0);
        check("fetch_halted", halted, 0);
        instr_ready = 1'($urandom);
        exec_done   = junk & 1'($urandom);
        jump_taken  = 1'b1;
        imem_rdata  = 16'($urandom);
        next();
        common();
        check("wait_en", imem_en, 0);
        check("wait_valid", instr_valid, 0);
        instr_ready = 1'($urandom);
        exec_done   = junk & 1'($urandom);
        imem_rdata  = w;
        next();
        for (int i = 0; i <= r; i++) begin
            common();
            check("issue_valid", instr_valid, 1);
            check("issue_opcode", opcode, w[15:11]);
            check("issue_operand", operand, w[10:0]);
            check("issue_en", imem_en, 0);
            instr_ready = (i == r);
            exec_done   = junk & 1'($urandom);
            imem_rdata  = 16'($urandom);
            next();
        end
        if (mode == 1) begin
            for (int k = 0; k < 10; k++) begin
                common();
                check("halt_flag", halted, 1);
                check("halt_en", imem_en, 0);
                check("halt_valid", instr_valid, 0);
                instr_ready = 1'($urandom);
                exec_done   = 1'($urandom);
                jump_taken  = 1'b1;
`ifdef FETCH_STEP_EN
                step = 1'b1;
`endif
                next();
            end
            exec_done = 1'b0;
            return;
        end
        for (int j = 0; j <= d; j++) begin
            common();
            check("exec_valid", instr_valid, 0);
            check("exec_en", imem_en, 0);
            check("exec_halted", halted, 0);
            instr_ready = 1'($urandom);
            exec_done   = (j == d);
            jump_taken  = (j == d) ? jt : 1'($urandom);
`ifdef FETCH_STEP_EN
            step = auto_step;
`endif
            if (mode == 2) begin
                rst_n      = 1'b0;
                acc_we     = 1'b0;
                exec_done  = 1'b1;
                jump_taken = 1'b1;
                return;
            end
            if (j == d) mpc = jt ? w[10:0] : 11'(mpc + 1);
            next();
        end
        exec_done  = 1'b0;
        jump_taken = 1'b0;
`ifdef FETCH_STEP_EN
        step = 1'b0;
`endif
    endtask

    initial begin
        ftab[0] = '{1'b1, 16'h0000, 1'b1, 1'b0};
        ftab[1] = '{1'b1, 16'h8001, 1'b0, 1'b1};
        ftab[2] = '{1'b0, 16'h0000, 1'b0, 1'b1};
        ftab[3] = '{1'b1, 16'h7fff, 1'b0, 1'b0};
        ftab[4] = '{1'b1, 16'hffff, 1'b0, 1'b1};
        ftab[5] = '{1'b1, 16'h0000, 1'b1, 1'b0};
        ftab[6] = '{1'b0, 16'h8000, 1'b1, 1'b0};
        ftab[7] = '{1'b1, 16'h0001, 1'b0, 1'b0};

        rst_n       = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        exec_done   = 1'b0;
        jump_taken  = 1'b0;
        acc_we      = 1'b0;
        acc_d       = '0;
        rand_acc    = 1'b0;
        junk        = 1'b0;
        mpc         = '0;
        mzr         = 1'b0;
        mng         = 1'b0;
`ifdef FETCH_STEP_EN
        step      = 1'b0;
        auto_step = 1'b1;
`endif
        for (int a = 0; a < 2048; a++) begin
            mem[a] = 16'($urandom);
            if (mem[a][15:11] == OP_HLT) mem[a][15:11] = 5'd0;
        end

        next();
        check_reset();
        release_rst();

        for (int a = 0; a < 3; a++) mem[a][15:11] = 5'd0;
        for (int k = 0; k < 3; k++) run_instr(0, 0, 1'b0, 0);
        check("linear_pc", pc, 3);

        mem[3] = {OP_JMP, 11'd100};
        run_instr(0, 0, 1'b1, 0);
        check("jump_addr", imem_addr, 100);
        mem[100] = {OP_JMP, 11'd2047};
        run_instr(1, 1, 1'b1, 0);
        mem[2047][15:11] = 5'b00011;
        run_instr(5, 1, 1'b0, 0);
        check("wrap_pc", pc, 0);

        rand_acc = 1'b1;
        junk     = 1'b1;
        for (int n = 0; n < 150; n++)
            run_instr(int'($urandom % 4), int'($urandom % 3), 1'($urandom), 0);

        mem[mpc] = {OP_HLT, 11'($urandom)};
        run_instr(2, 0, 1'b0, 1);
        rand_acc = 1'b0;
        for (int v = 0; v < 8; v++) begin
            acc_we = ftab[v].we;
            acc_d  = ftab[v].d;
            next();
            check("tab_zr", zr, ftab[v].zr);
            check("tab_ng", ng, ftab[v].ng);
            check("tab_halted", halted, 1);
            check("tab_en", imem_en, 0);
        end
        acc_we = 1'b0;
        mzr    = ftab[7].zr;
        mng    = ftab[7].ng;

        check_reset();
        release_rst();
        rand_acc = 1'b1;
        run_instr(0, 0, 1'b0, 0);
        check("pre_abort_pc", pc, 1);
        run_instr(1, 1, 1'b0, 2);
        check_reset();
        release_rst();
        run_instr(0, 0, 1'b0, 0);

`ifdef FETCH_STEP_EN
        check_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            next();
            common();
            check("nostep_en", imem_en, 0);
        end
        step = 1'b1;
        next();
        step = 1'b0;
        auto_step = 1'b1;
        run_instr(0, 2, 1'b0, 0);
        auto_step = 1'b0;
        run_instr(0, 0, 1'b0, 0);
        for (int k = 0; k < 10; k++) begin
            common();
            check("step_once_en", imem_en, 0);
            next();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
